// File: rtl/sram_like_bridge.sv
// Bridge from a single-cycle SRAM-style CPU port to a req/addr_ok/data_ok SRAM-like bus.
// Generates the core stall, cancels flushed accesses and holds the load result while frozen.
module sram_like_bridge #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  cpu_en,
  input  logic [DATA_W/8-1:0]   cpu_wen,
  input  logic [ADDR_W-1:0]     cpu_addr,
  input  logic [DATA_W-1:0]     cpu_wdata,
  output logic [DATA_W-1:0]     cpu_rdata,
  output logic                  cpu_stall,
  input  logic                  cpu_hold,
  input  logic                  cpu_flush,
  output logic                  req,
  output logic                  wr,
  output logic [1:0]            size,
  output logic [ADDR_W-1:0]     addr,
  output logic [DATA_W-1:0]     wdata,
  input  logic                  addr_ok,
  input  logic                  data_ok,
  input  logic [DATA_W-1:0]     rdata
);

  localparam int BYTES = DATA_W / 8;
  localparam int LOG2B = (DATA_W == 64) ? 3 : 2;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  state_t              state_r;
  logic                cancel_r;
  logic                req_r;
  logic                wr_r;
  logic [1:0]          size_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [DATA_W-1:0]   wdata_r;
  logic [DATA_W-1:0]   result_r;

  logic                accept_s;
  logic [LOG2B+1:0]    strobe_dec_s;
  logic [1:0]          size_next_s;
  logic [ADDR_W-1:0]   addr_next_s;

  // Returns {size, low address bits} for a strobe pattern; illegal patterns fall back to a full-width access.
  function automatic logic [LOG2B+1:0] decode_strobes(input logic [BYTES-1:0] wen);
    logic [LOG2B+1:0] res;
    logic [BYTES-1:0] mask;
    res = {2'(LOG2B), {LOG2B{1'b0}}};
    for (int s = 0; s <= LOG2B; s++) begin
      for (int o = 0; o < BYTES; o += (1 << s)) begin
        mask = BYTES'(((1 << (1 << s)) - 1) << o);
        if (wen == mask) begin
          res = {2'(s), LOG2B'(o)};
        end else begin
          res = res;
        end
      end
    end
    return res;
  endfunction

  assign accept_s = cpu_en & ~cpu_flush;

  // Bus size and address for the access being accepted.
  always_comb begin
    strobe_dec_s = decode_strobes(cpu_wen);
    if (cpu_wen == {BYTES{1'b0}}) begin
      size_next_s = 2'(LOG2B);
      addr_next_s = {cpu_addr[ADDR_W-1:LOG2B], {LOG2B{1'b0}}};
    end else begin
      size_next_s = strobe_dec_s[LOG2B+1:LOG2B];
      addr_next_s = {cpu_addr[ADDR_W-1:LOG2B], strobe_dec_s[LOG2B-1:0]};
    end
  end

  // Stall is combinational so the core freezes in the very cycle it requests.
  always_comb begin
    case (state_r)
      IDLE:    cpu_stall = accept_s;
      ADDR:    cpu_stall = 1'b1;
      DATA:    cpu_stall = 1'b1;
      DONE:    cpu_stall = 1'b0;
      default: cpu_stall = 1'b0;
    endcase
  end

  // Access sequencer: latches the request, drives the bus and captures the result.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r  <= IDLE;
      cancel_r <= 1'b0;
      req_r    <= 1'b0;
      wr_r     <= 1'b0;
      size_r   <= 2'd0;
      addr_r   <= {ADDR_W{1'b0}};
      wdata_r  <= {DATA_W{1'b0}};
      result_r <= {DATA_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            state_r  <= ADDR;
            req_r    <= 1'b1;
            wr_r     <= |cpu_wen;
            size_r   <= size_next_s;
            addr_r   <= addr_next_s;
            wdata_r  <= cpu_wdata;
            cancel_r <= 1'b0;
          end
        end
        ADDR: begin
          // A request cannot be withdrawn, so a flush here only marks it cancelled.
          if (cpu_flush) begin
            cancel_r <= 1'b1;
          end
          if (addr_ok) begin
            req_r   <= 1'b0;
            state_r <= DATA;
          end
        end
        DATA: begin
          if (data_ok) begin
            cancel_r <= 1'b0;
            if (cancel_r || cpu_flush) begin
              state_r <= IDLE;
            end else begin
              result_r <= rdata;
              state_r  <= DONE;
            end
          end else if (cpu_flush) begin
            cancel_r <= 1'b1;
          end
        end
        DONE: begin
          if (!cpu_hold || cpu_flush) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
          req_r   <= 1'b0;
        end
      endcase
    end
  end

  assign req       = req_r;
  assign wr        = wr_r;
  assign size      = size_r;
  assign addr      = addr_r;
  assign wdata     = wdata_r;
  assign cpu_rdata = result_r;

endmodule

// File: tb/tb_sram_like_bridge.sv
// Self-checking bench for sram_like_bridge: 32-bit instance with a delay-programmable bus slave,
// plus a 64-bit instance driven by hand.
module tb_sram_like_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic resetn = 1'b0;

  logic        cpu_en = 1'b0, cpu_hold = 1'b0, cpu_flush = 1'b0;
  logic [3:0]  cpu_wen = 4'h0;
  logic [31:0] cpu_addr = 32'h0, cpu_wdata = 32'h0, cpu_rdata;
  logic        cpu_stall, req, wr;
  logic        addr_ok = 1'b0, data_ok = 1'b0;
  logic [1:0]  size;
  logic [31:0] addr, wdata, rdata = 32'h0;

  logic        en64 = 1'b0, hold64 = 1'b0, flush64 = 1'b0, stall64, req64, wr64;
  logic        aok64 = 1'b0, dok64 = 1'b0;
  logic [7:0]  wen64 = 8'h0;
  logic [31:0] cpu_addr64 = 32'h0, addr64;
  logic [63:0] cpu_wdata64 = 64'h0, cpu_rdata64, wdata64, rdata64 = 64'h0;
  logic [1:0]  size64;

  sram_like_bridge #(.DATA_W(32), .ADDR_W(32)) dut (
    .clk(clk), .resetn(resetn), .cpu_en(cpu_en), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .cpu_hold(cpu_hold),
    .cpu_flush(cpu_flush), .req(req), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
    .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata));

  sram_like_bridge #(.DATA_W(64), .ADDR_W(32)) dut64 (
    .clk(clk), .resetn(resetn), .cpu_en(en64), .cpu_wen(wen64), .cpu_addr(cpu_addr64),
    .cpu_wdata(cpu_wdata64), .cpu_rdata(cpu_rdata64), .cpu_stall(stall64), .cpu_hold(hold64),
    .cpu_flush(flush64), .req(req64), .wr(wr64), .size(size64), .addr(addr64), .wdata(wdata64),
    .addr_ok(aok64), .data_ok(dok64), .rdata(rdata64));

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bus slave for the 32-bit instance: addr_ok after a_dly waits, data_ok d_dly cycles later.
  int a_dly = 0, d_dly = 0, s_phase = 0, s_cnt = 0, n_accept = 0;
  logic [31:0] s_rdata = 32'h0, cap_addr = 32'h0, cap_wdata = 32'h0;
  logic [1:0]  cap_size = 2'd0;
  logic        cap_wr = 1'b0;

  initial forever begin
    @(negedge clk);
    if (!resetn) begin
      s_phase = 0; s_cnt = 0; addr_ok = 1'b0; data_ok = 1'b0;
    end else begin
      addr_ok = 1'b0;
      data_ok = 1'b0;
      if (s_phase == 0) begin
        if (req === 1'b1) begin
          if (s_cnt == a_dly) begin
            addr_ok = 1'b1; cap_addr = addr; cap_size = size; cap_wr = wr; cap_wdata = wdata;
            n_accept++; s_phase = 1; s_cnt = 0;
          end else s_cnt++;
        end
      end else begin
        if (s_cnt == d_dly) begin
          data_ok = 1'b1; rdata = s_rdata; s_phase = 0; s_cnt = 0;
        end else s_cnt++;
      end
    end
  end

  // Reference: bus size/address from the strobe rules, by counting bytes.
  task automatic model_bus(input logic [3:0] wen, input logic [31:0] a,
                           output logic [1:0] es, output logic [31:0] ea);
    int cnt, low;
    logic legal;
    cnt = 0; low = -1;
    for (int i = 0; i < 4; i++) if (wen[i]) begin cnt++; if (low < 0) low = i; end
    legal = (cnt == 1 || cnt == 2 || cnt == 4) && (low % cnt == 0) &&
            (32'(wen >> low) == 32'((1 << cnt) - 1));
    if (cnt == 0 || !legal) begin
      es = 2'd2; ea = a & ~32'h3;
    end else begin
      es = (cnt == 1) ? 2'd0 : (cnt == 2) ? 2'd1 : 2'd2;
      ea = (a & ~32'h3) | 32'(low);
    end
  endtask

  task automatic run_access(input logic [3:0] wen, input logic [31:0] a, input logic [31:0] wd,
                            input int ad, input int dd, input logic [31:0] rv, input int hold_n,
                            input logic [1:0] es, input logic [31:0] ea, input int estall);
    int n, acc0;
    a_dly = ad; d_dly = dd; s_rdata = rv; acc0 = n_accept;
    cpu_en = 1'b1; cpu_wen = wen; cpu_addr = a; cpu_wdata = wd; cpu_hold = 1'b0; cpu_flush = 1'b0;
    n = 0;
    #1;
    while (cpu_stall === 1'b1 && n < 40) begin
      n++;
      @(negedge clk); #1;
    end
    chk("stall_cycles", 64'(n), 64'(estall));
    chk("bus_accepts", 64'(n_accept - acc0), 64'd1);
    chk("bus_addr", cap_addr, ea);
    chk("bus_size", cap_size, es);
    chk("bus_wr", cap_wr, wen != 4'h0);
    if (wen != 4'h0) chk("bus_wdata", cap_wdata, wd);
    else chk("cpu_rdata", cpu_rdata, rv);
    cpu_en = 1'b0;
    cpu_hold = (hold_n > 0);
    for (int i = 0; i < hold_n; i++) begin
      @(negedge clk); #1;
      chk("hold_stall", cpu_stall, 1'b0);
      chk("hold_no_req", req, 1'b0);
      if (wen == 4'h0) chk("hold_rdata", cpu_rdata, rv);
    end
    cpu_hold = 1'b0;
    @(negedge clk); #1;
  endtask

  // Flushes a read at cycle fcyc, then proves the bridge is IDLE by issuing a fresh read.
  task automatic flush_seq(input int ad, input int dd, input int fcyc);
    int c, nreq;
    logic [31:0] prev;
    prev = cpu_rdata; a_dly = ad; d_dly = dd; s_rdata = 32'hBAD0BAD0;
    cpu_en = 1'b1; cpu_wen = 4'h0; cpu_addr = 32'h00002000; cpu_hold = 1'b0; cpu_flush = 1'b0;
    c = 0; nreq = 0;
    #1;
    while (cpu_stall === 1'b1 && c < 40) begin
      if (req === 1'b1) nreq++;
      cpu_flush = (c == fcyc);
      if (c == fcyc) cpu_en = 1'b0;
      c++;
      @(negedge clk); #1;
    end
    cpu_flush = 1'b0;
    chk("flush_stall_cycles", 64'(c), 64'(3 + ad + dd));
    chk("flush_req_cycles", 64'(nreq), 64'(ad + 1));
    chk("flush_rdata_kept", cpu_rdata, prev);
    run_access(4'h0, 32'h00002104, 32'h0, 0, 0, 32'hC0FFEE00 + 32'(fcyc), 0, 2'd2, 32'h00002104, 3);
  endtask

  task automatic access64(input logic [7:0] wen, input logic [31:0] a, input logic [63:0] wd,
                          input logic [63:0] rv, input logic [1:0] es, input logic [31:0] ea);
    en64 = 1'b1; wen64 = wen; cpu_addr64 = a; cpu_wdata64 = wd;
    #1;
    chk("stall64_idle", stall64, 1'b1);
    @(negedge clk); #1;
    chk("req64", req64, 1'b1);
    chk("size64", size64, es);
    chk("addr64", addr64, ea);
    chk("wr64", wr64, wen != 8'h0);
    if (wen != 8'h0) chk("wdata64", wdata64, wd);
    aok64 = 1'b1;
    @(negedge clk); #1;
    aok64 = 1'b0; dok64 = 1'b1; rdata64 = rv;
    @(negedge clk); #1;
    dok64 = 1'b0;
    chk("stall64_done", stall64, 1'b0);
    if (wen == 8'h0) chk("rdata64", cpu_rdata64, rv);
    en64 = 1'b0;
    @(negedge clk); #1;
  endtask

  typedef struct {
    logic [3:0]  wen;
    logic [31:0] a;
    logic [31:0] wd;
    int          ad;
    int          dd;
    logic [31:0] rv;
    int          hold_n;
    logic [1:0]  es;
    logic [31:0] ea;
    int          estall;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [3:0]  rw;
    logic [31:0] ra, rd, rr, mea;
    logic [1:0]  mes;
    int          rad, rdd;

    vecs[0] = '{4'h0, 32'h1FC00004, 32'h0,        1, 1, 32'hDEADBEEF, 0, 2'd2, 32'h1FC00004, 5};
    vecs[1] = '{4'h4, 32'h80000010, 32'h00AB0000, 0, 0, 32'h0,        0, 2'd0, 32'h80000012, 3};
    vecs[2] = '{4'hC, 32'h80000010, 32'hCAFE0000, 0, 1, 32'h0,        0, 2'd1, 32'h80000012, 4};
    vecs[3] = '{4'h0, 32'h00001003, 32'h0,        0, 0, 32'h12345678, 4, 2'd2, 32'h00001000, 3};
    vecs[4] = '{4'h6, 32'h80000013, 32'h00112200, 2, 0, 32'h0,        0, 2'd2, 32'h80000010, 5};
    vecs[5] = '{4'hF, 32'h40000006, 32'hA5A5A5A5, 0, 0, 32'h0,        0, 2'd2, 32'h40000004, 3};
    vecs[6] = '{4'h3, 32'h40000001, 32'h00005566, 0, 2, 32'h0,        0, 2'd1, 32'h40000000, 5};
    vecs[7] = '{4'h8, 32'h00000007, 32'h77000000, 3, 3, 32'h0,        1, 2'd0, 32'h00000007, 9};
    vecs[8] = '{4'hA, 32'h00000008, 32'h11223344, 0, 0, 32'h0,        0, 2'd2, 32'h00000008, 3};
    vecs[9] = '{4'h7, 32'h00000004, 32'h00332211, 0, 0, 32'h0,        2, 2'd2, 32'h00000004, 3};

    // Reset state, including stall following cpu_en during reset.
    #1;
    chk("rst_stall", cpu_stall, 1'b0);
    chk("rst_req", req, 1'b0);
    chk("rst_addr", addr, 32'h0);
    chk("rst_rdata", cpu_rdata, 32'h0);
    cpu_en = 1'b1; #1;
    chk("rst_stall_follows_en", cpu_stall, 1'b1);
    cpu_en = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk); #1;

    for (int i = 0; i < 10; i++)
      run_access(vecs[i].wen, vecs[i].a, vecs[i].wd, vecs[i].ad, vecs[i].dd, vecs[i].rv,
                 vecs[i].hold_n, vecs[i].es, vecs[i].ea, vecs[i].estall);

    // Flushes: early in ADDR with slow addr_ok, with addr_ok, with data_ok, and mid-DATA.
    flush_seq(3, 0, 1);
    flush_seq(0, 0, 1);
    flush_seq(0, 0, 2);
    flush_seq(1, 2, 4);

    // Flush in IDLE cancels the request before anything is issued.
    begin
      int acc0;
      acc0 = n_accept;
      cpu_en = 1'b1; cpu_flush = 1'b1; #1;
      chk("idle_flush_stall", cpu_stall, 1'b0);
      @(negedge clk); #1;
      chk("idle_flush_req", req, 1'b0);
      cpu_en = 1'b0; cpu_flush = 1'b0;
      @(negedge clk); #1;
      chk("idle_flush_accepts", 64'(n_accept - acc0), 64'd0);
    end

    for (int i = 0; i < 30; i++) begin
      rw  = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      ra  = $urandom; rd = $urandom; rr = $urandom;
      rad = $urandom_range(0, 3); rdd = $urandom_range(0, 3);
      model_bus(rw, ra, mes, mea);
      run_access(rw, ra, rd, rad, rdd, rr, $urandom_range(0, 2), mes, mea, 3 + rad + rdd);
    end

    // Reset while waiting in DATA abandons the access.
    a_dly = 0; d_dly = 3; s_rdata = 32'h55AA55AA;
    cpu_en = 1'b1; cpu_wen = 4'h0; cpu_addr = 32'h00003000;
    repeat (2) @(negedge clk);
    #1;
    resetn = 1'b0; #1;
    chk("rst_mid_req", req, 1'b0);
    chk("rst_mid_addr", addr, 32'h0);
    chk("rst_mid_size", size, 2'd0);
    chk("rst_mid_wr", wr, 1'b0);
    chk("rst_mid_wdata", wdata, 32'h0);
    chk("rst_mid_rdata", cpu_rdata, 32'h0);
    chk("rst_mid_stall", cpu_stall, 1'b1);
    cpu_en = 1'b0; #1;
    chk("rst_mid_stall_off", cpu_stall, 1'b0);
    @(negedge clk); #1;
    resetn = 1'b1;
    @(negedge clk); #1;
    run_access(4'h0, 32'h00003008, 32'h0, 1, 0, 32'h0BADCAFE, 0, 2'd2, 32'h00003008, 4);

    access64(8'h00, 32'h00000008, 64'h0, 64'h0123456789ABCDEF, 2'd3, 32'h00000008);
    access64(8'hF0, 32'h00000008, 64'hDEADBEEF00000000, 64'h0, 2'd2, 32'h0000000C);
    access64(8'h03, 32'h00000015, 64'h000000000000BEEF, 64'h0, 2'd1, 32'h00000010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/sram_like_bridge.md
# sram_like_bridge

Parametrised bridge between the CPU core's single-cycle SRAM-style memory port and a handshaked SRAM-like bus (req/addr_ok/data_ok). The core top instantiates one per port, instruction and data, with core and bus unchanged. Added over the plain SRAM port:
- stall generation;
- configurable data width;
- flush cancellation of in-flight accesses;
- result holding while the pipeline is frozen by another stall source.

## Interface
Parameters:
- DATA_W, default 32: data width in bits; legal values 32 or 64. BYTES = DATA_W/8.
- ADDR_W, default 32: byte address width.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- cpu_en  in  1  access request; held stable by the core while cpu_stall=1.
- cpu_wen  in  BYTES  byte write strobes; all zero = read.
- cpu_addr  in  ADDR_W  byte address.
- cpu_wdata  in  DATA_W  store data, byte lanes aligned to the strobes.
- cpu_rdata  out  DATA_W  load result; valid while state=DONE.
- cpu_stall  out  1  core must freeze.
- cpu_hold  in  1  pipeline frozen by another source; result is kept.
- cpu_flush  in  1  exception/branch flush; cancels the access.
- req  out  1  bus request.
- wr  out  1  1 = write.
- size  out  2  log2 of bytes transferred.
- addr  out  ADDR_W  bus byte address.
- wdata  out  DATA_W  bus write data.
- addr_ok  in  1  request accepted this cycle.
- data_ok  in  1  response this cycle; rdata valid for reads.
- rdata  in  DATA_W  bus read data.

## Operation
States: IDLE, ADDR, DATA, DONE. One access in flight at most. A cancel flag marks a flushed access.

IDLE
- cpu_en=1 and cpu_flush=0: latch wr, size, addr and wdata; go to ADDR.
- cpu_en=1 and cpu_flush=1: stay IDLE; nothing is issued.

ADDR
- req=1, with the latched fields held constant.
- addr_ok=1: go to DATA.
- Flush does not drop req. Protocol forbids withdrawing a request, so a flush only sets cancel.

DATA
- Wait for data_ok. data_ok is sampled only in DATA; the slave guarantees at least 1 cycle after addr_ok.
- data_ok with cancel=0: capture rdata into the result register; go to DONE.
- data_ok with cancel=1: clear cancel; go to IDLE.
- Flush in this state sets cancel.

DONE
- cpu_stall=0 and cpu_rdata = result register.
- cpu_hold=0 or cpu_flush=1: go to IDLE.

cpu_stall, combinational:
- 1 in ADDR and DATA;
- 1 in IDLE when cpu_en=1 and cpu_flush=0;
- 0 otherwise.

Size and address derivation:
- Reads: size = log2(BYTES); addr = cpu_addr with the low log2(BYTES) bits cleared.
- Writes: size = log2(popcount(cpu_wen)); addr low bits = index of the lowest set strobe.
- Legal strobe patterns: contiguous, naturally aligned, power-of-two count. Any other pattern is an error; it issues size=log2(BYTES) with the address aligned.

Writes complete through DONE like reads; cpu_rdata is don't-care for writes.

## Timing
Reset values (resetn=0, asynchronous):
- state=IDLE, cancel=0;
- req=0, wr=0, size=0, addr=0, wdata=0, cpu_rdata=0;
- cpu_stall follows cpu_en.
- Reset mid-access abandons the access. The bus slave is reset by the same resetn.

Best-case sequence, with cpu_en at cycle 0:
- cycle 0: IDLE, stall=1;
- cycle 1: ADDR, req=1, addr_ok=1;
- cycle 2: DATA, data_ok=1;
- cycle 3: DONE, stall=0, data delivered.

Best-case latency is 3 cycles stalled plus the delivery cycle. Each addr_ok or data_ok wait cycle adds 1.

Back-to-back accesses:
- A new cpu_en is accepted in the IDLE cycle that follows DONE.
- Minimum issue interval is 4 cycles.

Other cycle-level rules:
- req is registered, so it is never combinationally dependent on addr_ok.
- A flush in the same cycle as addr_ok still counts as cancelled.
- A flush in the same cycle as data_ok in DATA suppresses DONE.

## Test plan
- Read, DATA_W=32: cpu_addr=0x1FC00004, addr_ok and data_ok each 1 cycle late, rdata=0xDEADBEEF. Required: req with addr=0x1FC00004, size=2, wr=0; stall high for 5 cycles; cpu_rdata=0xDEADBEEF in DONE.
- Byte store, DATA_W=32: cpu_wen=0100, cpu_addr=0x80000010. Required: wr=1, size=0, addr=0x80000012. Halfword store with wen=1100 gives size=1, addr=0x80000012.
- Flush in ADDR with addr_ok delayed 3 cycles. Required: req held until addr_ok; data_ok then returns to IDLE with no DONE; next cpu_en issues normally.
- cpu_hold=1 for 4 cycles in DONE. Required: cpu_rdata stable at 0x12345678 and stall=0 throughout; no new req until hold drops.
- DATA_W=64, read at 0x8. Required: size=3, addr=0x8, full 64-bit rdata returned. Store with wen=11110000 gives size=2, addr=0xC.
- Reset asserted in DATA. Required: outputs go to their reset values immediately; after release, a fresh read completes correctly.
